// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the streaming Sobel edge detector.
package sobel_pkg;

    localparam logic MODE_L1  = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // The L1 sum of two DATA_W+2 bit magnitudes needs one more bit.
    function automatic int mag_width(input int data_w);
        return data_w + 3;
    endfunction

    function automatic int grad_width(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_stream_line_buffer.sv
// One-row pixel store: single write port, registered read port that
// returns the old contents when the same address is written in that cycle.
module line_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel detector: raster pixels in, registered gradient
// magnitude and edge flag out two cycles after each interior beat.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    localparam int MAG_W = mag_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic [MAG_W-1:0]  thresh,
    output logic              out_valid,
    output logic [MAG_W-1:0]  out_mag,
    output logic              out_edge,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done
);

    localparam int GW = grad_width(DATA_W);
    localparam int AW = DATA_W + 2;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic first_beat, last_beat, interior;

    assign first_beat = in_valid && (col_reg == '0) && (row_reg == '0);
    assign last_beat  = in_valid && (col_reg == CW'(IMG_W - 1)) && (row_reg == RW'(IMG_H - 1));
    assign interior   = in_valid && (col_reg >= CW'(2)) && (row_reg >= RW'(2));

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (in_valid) begin
            if (col_reg == CW'(IMG_W - 1)) begin
                col_next = '0;
                row_next = (row_reg == RW'(IMG_H - 1)) ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
        if (rst) begin
            col_next = '0;
            row_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        col_reg <= col_next;
        row_reg <= row_next;
    end

    // Reads are addressed with the upcoming column so the registered read
    // data lines up with the pixel presented on the following beat.
    logic [DATA_W-1:0] rd0, rd1;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (in_valid && !rst),
        .wr_addr (col_reg),
        .wr_data (in_data),
        .rd_addr (col_next),
        .rd_data (rd0)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (in_valid && !rst),
        .wr_addr (col_reg),
        .wr_data (rd0),
        .rd_addr (col_next),
        .rd_data (rd1)
    );

    // S0: window shift, index 2 is the newest column.
    logic [DATA_W-1:0] win_t [0:2];
    logic [DATA_W-1:0] win_m [0:2];
    logic [DATA_W-1:0] win_b [0:2];

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_win
        logic [DATA_W-1:0] t_src, m_src, b_src;
        if (gi == 2) begin : g_head
            assign t_src = rd1;
            assign m_src = rd0;
            assign b_src = in_data;
        end else begin : g_tail
            assign t_src = win_t[gi + 1];
            assign m_src = win_m[gi + 1];
            assign b_src = win_b[gi + 1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                win_t[gi] <= '0;
                win_m[gi] <= '0;
                win_b[gi] <= '0;
            end else if (in_valid) begin
                win_t[gi] <= t_src;
                win_m[gi] <= m_src;
                win_b[gi] <= b_src;
            end
        end
    end

    logic             v0_reg, sof0_reg, eol0_reg, mode_reg;
    logic [MAG_W-1:0] thresh_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_reg     <= 1'b0;
            sof0_reg   <= 1'b0;
            eol0_reg   <= 1'b0;
            mode_reg   <= MODE_L1;
            thresh_reg <= '0;
            frame_done <= 1'b0;
        end else begin
            v0_reg     <= interior;
            sof0_reg   <= interior && (col_reg == CW'(2)) && (row_reg == RW'(2));
            eol0_reg   <= interior && (col_reg == CW'(IMG_W - 1));
            frame_done <= last_beat;
            if (first_beat) begin
                mode_reg   <= mode;
                thresh_reg <= thresh;
            end
        end
    end

    // S1: gradients as two's complement differences of non-negative sums.
    logic [GW-1:0] pos_x, neg_x, pos_y, neg_y;
    logic [GW-1:0] gx_reg, gy_reg;
    logic             v1_reg, sof1_reg, eol1_reg, mode1_reg;
    logic [MAG_W-1:0] thresh1_reg;

    always_comb begin
        pos_x = GW'(win_t[2]) + (GW'(win_m[2]) << 1) + GW'(win_b[2]);
        neg_x = GW'(win_t[0]) + (GW'(win_m[0]) << 1) + GW'(win_b[0]);
        pos_y = GW'(win_b[0]) + (GW'(win_b[1]) << 1) + GW'(win_b[2]);
        neg_y = GW'(win_t[0]) + (GW'(win_t[1]) << 1) + GW'(win_t[2]);
    end

    // Mode/threshold travel with the data so a new frame's latch cannot
    // affect results still in flight from the previous frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_reg      <= '0;
            gy_reg      <= '0;
            v1_reg      <= 1'b0;
            sof1_reg    <= 1'b0;
            eol1_reg    <= 1'b0;
            mode1_reg   <= MODE_L1;
            thresh1_reg <= '0;
        end else begin
            gx_reg      <= pos_x - neg_x;
            gy_reg      <= pos_y - neg_y;
            v1_reg      <= v0_reg;
            sof1_reg    <= sof0_reg;
            eol1_reg    <= eol0_reg;
            mode1_reg   <= mode_reg;
            thresh1_reg <= thresh_reg;
        end
    end

    // S2: absolute values, combine, compare.
    logic [AW-1:0]    abs_x, abs_y;
    logic [MAG_W-1:0] mag_c;

    always_comb begin
        abs_x = gx_reg[GW-1] ? AW'(~gx_reg + GW'(1)) : AW'(gx_reg);
        abs_y = gy_reg[GW-1] ? AW'(~gy_reg + GW'(1)) : AW'(gy_reg);
        if (mode1_reg == MODE_MAX) begin
            mag_c = MAG_W'((abs_x >= abs_y) ? abs_x : abs_y);
        end else begin
            mag_c = MAG_W'(abs_x) + MAG_W'(abs_y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_edge  <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= v1_reg;
            out_sof   <= sof1_reg;
            out_eol   <= eol1_reg;
            if (v1_reg) begin
                out_mag  <= mag_c;
                out_edge <= (mag_c >= thresh1_reg);
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on an 8x6 image: the driver queues
// expected results, a negedge monitor pops and compares them.
module tb_sobel_stream;

    localparam int DW = 8;
    localparam int W = 8;
    localparam int H = 6;
    localparam int MW = 11;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst, in_valid, mode;
    logic [DW-1:0] in_data;
    logic [MW-1:0] thresh;
    logic out_valid, out_edge, out_sof, out_eol, frame_done;
    logic [MW-1:0] out_mag;

    sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .mode       (mode),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .out_mag    (out_mag),
        .out_edge   (out_edge),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_seen <= rst;
    end

    typedef struct {
        int mag;
        bit edg;
        bit sof;
        bit eol;
        longint cyc;
        int frm;
    } exp_t;

    exp_t exp_q[$];
    longint fd_q[$];
    int img[NPIX];
    int frame_id = 0;
    int checks = 0;
    int failures = 0;
    int n_out, n_sof, n_eol, n_1020, n_edge, sum_mag, n_fd;
    int sum_frm[2];

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    function automatic exp_t model(input int r, input int c, input bit m, input int th, input longint cy);
        int gx, gy, ax, ay;
        exp_t e;
        gx = (px(r-2, c) + 2 * px(r-1, c) + px(r, c)) - (px(r-2, c-2) + 2 * px(r-1, c-2) + px(r, c-2));
        gy = (px(r, c-2) + 2 * px(r, c-1) + px(r, c)) - (px(r-2, c-2) + 2 * px(r-2, c-1) + px(r-2, c));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        e.mag = m ? ((ax > ay) ? ax : ay) : ax + ay;
        e.edg = (e.mag >= th);
        e.sof = (r == 2) && (c == 2);
        e.eol = (c == W - 1);
        e.cyc = cy;
        e.frm = frame_id;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_seen) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_mag", out_mag, 0);
            chk("rst_out_edge", out_edge, 0);
            chk("rst_out_sof", out_sof, 0);
            chk("rst_out_eol", out_eol, 0);
            chk("rst_frame_done", frame_done, 0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_mag", out_mag, e.mag);
                    chk("out_edge", out_edge, e.edg);
                    chk("out_sof", out_sof, e.sof);
                    chk("out_eol", out_eol, e.eol);
                    chk("out_latency_cycle", cyc, e.cyc);
                    $display("result frm=%0d mag=%0d edge=%0b sof=%0b eol=%0b cyc=%0d",
                             e.frm, out_mag, out_edge, out_sof, out_eol, cyc);
                    n_out++;
                    n_sof += int'(out_sof);
                    n_eol += int'(out_eol);
                    n_edge += int'(out_edge);
                    if (out_mag == 11'd1020) n_1020++;
                    sum_mag += int'(out_mag);
                    sum_frm[e.frm % 2] += int'(out_mag);
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    chk("frame_done_cycle", cyc, fd_q.pop_front());
                    n_fd++;
                end
            end
        end
    end

    task automatic clr_stats();
        n_out = 0; n_sof = 0; n_eol = 0; n_1020 = 0; n_edge = 0; sum_mag = 0; n_fd = 0;
        sum_frm[0] = 0; sum_frm[1] = 0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Drives one frame from img[]; after the first beat mode/thresh are
    // scrambled, which must not affect the frame. stop_at >= 0 applies a
    // one-cycle reset right after that beat.
    task automatic drive_frame(input bit m, input int th, input int gap_pct, input int stop_at);
        int r, c;
        frame_id++;
        for (int i = 0; i < NPIX; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data = DW'(img[i]);
            if (i == 0) begin
                mode = m;
                thresh = MW'(th);
            end else begin
                mode = ~m;
                thresh = MW'(th ^ 'h2AA);
            end
            r = i / W;
            c = i % W;
            if (r >= 2 && c >= 2) exp_q.push_back(model(r, c, m, th, cyc + 3));
            if (i == NPIX - 1) fd_q.push_back(cyc + 1);
            if (i == stop_at) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                #1;
                exp_q.delete();
                fd_q.delete();
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fd_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, exp_q.size() + fd_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        mode = 1'b0;
        thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Flat frame: no gradient anywhere.
        clr_stats();
        for (int i = 0; i < NPIX; i++) img[i] = 100;
        drive_frame(1'b0, 1, 0, -1);
        idle();
        drain("flat_drain");
        chk("flat_results", n_out, 24);
        chk("flat_sof_count", n_sof, 1);
        chk("flat_eol_count", n_eol, 4);
        chk("flat_edge_count", n_edge, 0);
        chk("flat_mag_sum", sum_mag, 0);
        chk("flat_frame_done", n_fd, 1);

        // Vertical step 0->255 between cols 3 and 4, then its mirror.
        for (int k = 0; k < 2; k++) begin
            clr_stats();
            for (int i = 0; i < NPIX; i++) img[i] = (((i % W) >= 4) != (k == 1)) ? 255 : 0;
            drive_frame(1'b0, 500, 0, -1);
            idle();
            drain("vstep_drain");
            chk("vstep_results", n_out, 24);
            chk("vstep_1020_count", n_1020, 8);
            chk("vstep_edge_count", n_edge, 8);
            chk("vstep_mag_sum", sum_mag, 8 * 1020);
        end

        // Horizontal step, max mode, threshold at full swing.
        clr_stats();
        for (int i = 0; i < NPIX; i++) img[i] = ((i / W) >= 3) ? 255 : 0;
        drive_frame(1'b1, 1020, 0, -1);
        idle();
        drain("hstep_drain");
        chk("hstep_1020_count", n_1020, 12);
        chk("hstep_edge_count", n_edge, 12);
        chk("hstep_mag_sum", sum_mag, 12 * 1020);

        // Diagonal step, L1 then max on back-to-back frames.
        clr_stats();
        for (int i = 0; i < NPIX; i++) img[i] = ((i / W) + (i % W) >= 7) ? 255 : 0;
        drive_frame(1'b0, 2000, 0, -1);
        drive_frame(1'b1, 2000, 0, -1);
        idle();
        drain("diag_drain");
        chk("diag_l1_vs_max", sum_frm[(frame_id - 1) % 2], 2 * sum_frm[frame_id % 2]);
        chk("diag_max_nonzero", int'(sum_frm[frame_id % 2] > 0), 1);
        chk("diag_frame_done", n_fd, 2);

        // Random pixels with ~50% input gaps.
        clr_stats();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
            drive_frame(f[0], int'($urandom_range(1000)), 50, -1);
        end
        idle();
        drain("rand_drain");
        chk("rand_results", n_out, 48);
        chk("rand_frame_done", n_fd, 2);

        // Reset at row 3 col 5, then a clean ramp frame.
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
        drive_frame(1'b0, 300, 0, 3 * W + 5);
        clr_stats();
        for (int i = 0; i < NPIX; i++) img[i] = (i / W) * 20 + (i % W) * 7;
        drive_frame(1'b0, 40, 0, -1);
        idle();
        drain("post_rst_drain");
        chk("post_rst_results", n_out, 24);
        chk("post_rst_sof_count", n_sof, 1);
        chk("post_rst_frame_done", n_fd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
